wshb_rr_arbiter: RTL
====================

Name: wshb_rr_arbiter

Overview:
N-to-1 Wishbone classic bus arbiter with round-robin fairness and an optional per-grant transfer quantum. It lets several video-path masters (pattern generator, VGA reader, future CPU/DMA port) share the single SDRAM Wishbone master port. It replaces the fixed two-master token scheme so that no master can starve the others.

Parameters:
N, 3, number of requesting masters (2..8)
AW, 32, address width
DW, 32, data width
QUANTUM, 16, max acks per grant while another master waits; 0 = unlimited

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
s_cyc  in  N  per-master cyc
s_stb  in  N  per-master stb
s_we  in  N  per-master we
s_adr  in  N x AW  per-master address (packed array)
s_dat_ms  in  N x DW  per-master write data
s_sel  in  N x DW/8  per-master byte select
s_cti  in  N x 3  per-master cycle type
s_bte  in  N x 2  per-master burst type
s_ack  out  N  per-master ack
s_err  out  N  per-master err
s_rty  out  N  per-master rty
s_dat_sm  out  DW  read data, broadcast to all masters
m_cyc, m_stb, m_we  out  1 each  to slave
m_adr  out  AW  to slave
m_dat_ms  out  DW  to slave
m_sel  out  DW/8  to slave
m_cti  out  3  to slave
m_bte  out  2  to slave
m_ack, m_err, m_rty  in  1 each  from slave
m_dat_sm  in  DW  read data from slave
grant  out  N  registered one-hot current owner; all zero when idle

Behaviour:
- Clock clk; reset rst synchronous, active-high; all state updates on rising clk.
- State: busy (1b), g (owner index), ptr (round-robin start index), cnt (ack counter). Reset: busy=0, g=0, ptr=0, cnt=0; hence grant=0, m_cyc=m_stb=0, all s_ack/s_err/s_rty=0.
- IDLE (busy=0): m_cyc=m_stb=0; other m_* driven from master g (don't-care). If any s_cyc set, winner = first index i in ptr, ptr+1, ..., ptr+N-1 (mod N) with s_cyc[i]=1; next cycle busy=1, g=winner, cnt=0. Arbitration latency: exactly 1 cycle from request to grant.
- GRANT (busy=1): m_cyc/m_stb/m_we/m_adr/m_dat_ms/m_sel/m_cti/m_bte = master g fields (combinational mux). s_ack[g]=m_ack, s_err[g]=m_err, s_rty[g]=m_rty; all other s_ack/s_err/s_rty=0. s_dat_sm=m_dat_sm always.
- cnt increments on every m_ack while busy.
- Normal release: s_cyc[g]=0 -> next cycle busy=0, ptr=(g+1) mod N.
- Forced release: QUANTUM!=0 and m_ack=1 and cnt==QUANTUM-1 and some other s_cyc[j]=1 (j!=g) -> next cycle busy=0, ptr=(g+1) mod N. The preempted master keeps cyc high, sees no ack, and re-arbitrates normally. Preemption only occurs on an ack edge, so no transfer is ever abandoned mid-stb.
- Quantum reached with no other requester: ownership kept; cnt wraps to 0.
- Every ownership change passes through IDLE, giving one m_cyc=0 cycle between owners so the slave can close any burst.
- Simultaneous release and new requests: release wins; the new winner is chosen from the updated ptr in the following IDLE cycle.
- Reset mid-transfer: next edge returns to reset state. m_cyc drops immediately. Any pending ack is lost.
- err and rty count as transfer termination for release purposes but do not increment cnt.

Decomposition:
- Package wshb_arb_pkg: index width function clog2(N), QUANTUM counter width, default cti/bte constants.
- Sub-module wshb_rr_pick: combinational round-robin priority encoder. Inputs are req[N] and ptr; outputs are winner index and any_req. It is reused by future arbiters.

Test Plan:
- Single master: s_cyc[0]=1 at t0, slave acks every cycle for 4 stb -> grant=001 at t1, 4 acks on s_ack[0] only. s_cyc[0] drops at t5, so m_cyc=0 and grant=000 at t6.
- Three masters: all raise cyc simultaneously after reset, each does 1 transfer then drops -> grant order 001,010,100, with one m_cyc=0 cycle between owners.
- Fairness: with ptr=2 (after master 1 served), masters 0 and 2 request together -> master 2 granted first, then 0.
- Quantum: QUANTUM=4, master 0 streams continuously, master 1 requests at ack 2 -> after 4th ack to master 0, one idle cycle, then grant=010. s_ack[0]=0 while master 1 owns; master 0 is regranted after master 1 releases.
- No contention: QUANTUM=4, master 0 alone for 10 acks -> grant never leaves 001 and m_cyc stays high throughout.
- Reset mid-transfer: rst=1 while grant=010 with stb pending -> next cycle m_cyc=0, grant=000. After rst drops, masters 1 and 2 request -> master 1 wins (ptr=0).

Source files
------------

// File: rtl/wshb_arb_pkg.sv
// Shared types and width helpers for the Wishbone round-robin arbiter family.
// Contents: arbiter state enum, idle-bus cycle-type/burst-type values,
// index-width and quantum-counter-width functions.
package wshb_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  // Values presented on m_cti/m_bte while no master owns the bus.
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  // Bits needed to hold a master index 0..n-1 (at least one bit).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Bits needed to count acks 0..q-1 (at least one bit, also for q == 0).
  function automatic int unsigned cnt_w(input int unsigned q);
    return (q < 2) ? 1 : $clog2(q);
  endfunction

endpackage

// File: rtl/wshb_rr_pick.sv
// Combinational round-robin priority encoder.
// Ports:
//   req     in  N   request vector
//   ptr     in  IW  index searched first; search continues ptr+1, ... mod N
//   winner  out IW  first requesting index in that order (0 when none)
//   any_req out 1   at least one request is set
module wshb_rr_pick
  import wshb_arb_pkg::*;
#(
  parameter  int unsigned N  = 3,
  localparam int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          any_req
);

  int idx;

  // Walk the rotated order backwards so the highest-priority hit is written last.
  always_comb begin
    winner  = '0;
    any_req = |req;
    idx     = 0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % int'(N);
      if (req[idx]) winner = IW'(idx);
    end
  end

endmodule

// File: rtl/wshb_rr_arbiter.sv
// N-to-1 Wishbone classic arbiter with round-robin fairness and an optional
// per-grant ack quantum (QUANTUM = 0 disables preemption).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   s_cyc/s_stb/s_we  [N]         per-master control
//   s_adr/s_dat_ms/s_sel/s_cti/s_bte  per-master packed payloads
//   s_ack/s_err/s_rty [N]         per-master termination, only owner sees them
//   s_dat_sm                      read data broadcast to all masters
//   m_*                           single slave-side Wishbone port
//   grant [N]                     registered one-hot owner, zero when idle
module wshb_rr_arbiter
  import wshb_arb_pkg::*;
#(
  parameter int unsigned N       = 3,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned QUANTUM = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           s_cyc,
  input  logic [N-1:0]           s_stb,
  input  logic [N-1:0]           s_we,
  input  logic [N-1:0][AW-1:0]   s_adr,
  input  logic [N-1:0][DW-1:0]   s_dat_ms,
  input  logic [N-1:0][DW/8-1:0] s_sel,
  input  logic [N-1:0][2:0]      s_cti,
  input  logic [N-1:0][1:0]      s_bte,
  output logic [N-1:0]           s_ack,
  output logic [N-1:0]           s_err,
  output logic [N-1:0]           s_rty,
  output logic [DW-1:0]          s_dat_sm,
  output logic                   m_cyc,
  output logic                   m_stb,
  output logic                   m_we,
  output logic [AW-1:0]          m_adr,
  output logic [DW-1:0]          m_dat_ms,
  output logic [DW/8-1:0]        m_sel,
  output logic [2:0]             m_cti,
  output logic [1:0]             m_bte,
  input  logic                   m_ack,
  input  logic                   m_err,
  input  logic                   m_rty,
  input  logic [DW-1:0]          m_dat_sm,
  output logic [N-1:0]           grant
);

  localparam int unsigned IW = idx_w(N);
  localparam int unsigned CW = cnt_w(QUANTUM);
  localparam logic [CW-1:0] QLAST = (QUANTUM == 0) ? '0 : CW'(QUANTUM - 1);

  arb_state_t    state, state_n;
  logic [IW-1:0] g, g_n;
  logic [IW-1:0] ptr, ptr_n;
  logic [IW-1:0] win;
  logic [CW-1:0] cnt, cnt_n;
  logic [N-1:0]  grant_n;
  logic [N-1:0]  g_oh;
  logic          any_req;
  logic          others;
  logic          quantum_hit;

  wshb_rr_pick #(.N(N)) u_pick (
    .req     (s_cyc),
    .ptr     (ptr),
    .winner  (win),
    .any_req (any_req)
  );

  assign g_oh        = N'(1) << g;
  assign others      = |(s_cyc & ~g_oh);
  assign quantum_hit = (QUANTUM != 0) && m_ack && (cnt == QLAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      g     <= '0;
      ptr   <= '0;
      cnt   <= '0;
      grant <= '0;
    end else begin
      state <= state_n;
      g     <= g_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
      grant <= grant_n;
    end
  end

  // Next state: every ownership change goes through ST_IDLE so m_cyc drops
  // for one cycle between owners; preemption only happens on an ack.
  always_comb begin
    state_n = state;
    g_n     = g;
    ptr_n   = ptr;
    cnt_n   = cnt;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          state_n = ST_GRANT;
          g_n     = win;
          cnt_n   = '0;
        end
      end
      ST_GRANT: begin
        if (m_ack) cnt_n = (cnt == QLAST) ? '0 : cnt + CW'(1);
        if (!s_cyc[g] || (quantum_hit && others)) begin
          state_n = ST_IDLE;
          ptr_n   = (g == IW'(N - 1)) ? '0 : g + IW'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
    grant_n = (state_n == ST_GRANT) ? (N'(1) << g_n) : '0;
  end

  // Bus mux and termination routing to the current owner.
  always_comb begin
    m_cyc    = 1'b0;
    m_stb    = 1'b0;
    m_we     = s_we[g];
    m_adr    = s_adr[g];
    m_dat_ms = s_dat_ms[g];
    m_sel    = s_sel[g];
    m_cti    = CTI_CLASSIC;
    m_bte    = BTE_LINEAR;
    s_ack    = '0;
    s_err    = '0;
    s_rty    = '0;
    if (state == ST_GRANT) begin
      m_cyc    = s_cyc[g];
      m_stb    = s_stb[g];
      m_cti    = s_cti[g];
      m_bte    = s_bte[g];
      s_ack[g] = m_ack;
      s_err[g] = m_err;
      s_rty[g] = m_rty;
    end
  end

  assign s_dat_sm = m_dat_sm;

endmodule
